// File: rtl/joy_pkg.sv
// Shared definitions for the joystick poll controller: register map, control
// and flag bit positions, FSM states and pad type codes.
package joy_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_PERIOD = 3'd1;
   localparam logic [2:0] ADDR_S1L    = 3'd2;
   localparam logic [2:0] ADDR_S1H    = 3'd3;
   localparam logic [2:0] ADDR_S2L    = 3'd4;
   localparam logic [2:0] ADDR_S2H    = 3'd5;
   localparam logic [2:0] ADDR_FLAGS  = 3'd6;
   localparam logic [2:0] ADDR_FRAME  = 3'd7;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_P1_EN   = 2;
   localparam int CTRL_P2_EN   = 3;
   localparam int CTRL_ONESHOT = 4;

   localparam int FLAG_P1      = 0;
   localparam int FLAG_P2      = 1;
   localparam int FLAG_TIMEOUT = 6;
   localparam int FLAG_BUSY    = 7;

   localparam logic [3:0] CTRL_RESET = 4'hC;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      BUSY    = 2'd2,
      CAPTURE = 2'd3
   } poll_state_t;

   typedef enum logic [1:0] {
      PAD_3BTN      = 2'b00,
      PAD_6BTN_PART = 2'b01,
      PAD_6BTN      = 2'b10
   } pad_type_t;

   // High register byte layout for a {type, status} pad word.
   function automatic logic [7:0] pad_high_byte(input logic [13:0] pad);
      return {pad[13:12], 2'b00, pad[11:8]};
   endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Poll rate generator: a CLK_DIV prescaler producing base ticks, and a period
// counter that raises poll_req once every PERIOD ticks (PERIOD 0 acts as 1).
module joy_tick_gen #(
   parameter int CLK_DIV = 240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] period,
   output logic       poll_req
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PW-1:0] pre_cnt;
   logic [7:0]    per_cnt;
   logic [7:0]    eff_period;
   logic          tick;

   assign eff_period = (period == 8'd0) ? 8'd1 : period;
   assign tick       = run && (pre_cnt == PW'(CLK_DIV - 1));
   // >= rather than == so lowering PERIOD mid-count cannot strand the counter
   assign poll_req   = tick && (({1'b0, per_cnt} + 9'd1) >= {1'b0, eff_period});

   // Holding both counters at zero while stopped gives a clean restart on run 0->1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
         per_cnt <= '0;
      end else if (!run) begin
         pre_cnt <= '0;
         per_cnt <= '0;
      end else begin
         if (tick) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PW'(1);
         end
         if (poll_req) begin
            per_cnt <= '0;
         end else if (tick) begin
            per_cnt <= per_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/joy_poll_ctrl.sv
// Poll scheduler and CPU register front-end for the two-port Sega joystick
// poller. Define JOY_DEBOUNCE_EN to require two matching captures per change.
module joy_poll_ctrl
   import joy_pkg::*;
#(
   parameter int CLK_DIV     = 240,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        rd,
   input  logic        wr,
   input  logic [2:0]  addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        irq,
   output logic        poll_start,
   input  logic        poll_busy,
   input  logic        poll_done,
   input  logic [11:0] status1,
   input  logic [11:0] status2,
   input  logic [1:0]  type1,
   input  logic [1:0]  type2
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   poll_state_t state, state_nxt;

   logic [3:0]    ctrl;
   logic [7:0]    period;
   logic [13:0]   shadow1, shadow2;
   logic [13:0]   cap1, cap2;
   logic [7:0]    hold1, hold2;
   logic          hold1_vld, hold2_vld;
   logic          flag_p1, flag_p2, flag_to;
   logic [7:0]    frame;
   logic [TW-1:0] to_cnt;

   logic poll_req;
   logic wr_en, rd_en;
   logic one_shot;
   logic timed_out;
   logic capt;
   logic upd1, upd2;
   logic set_to;
   logic flags_w1c;

   assign wr_en     = cs && wr;
   assign rd_en     = cs && rd;
   assign one_shot  = wr_en && (addr == ADDR_CTRL) && wdata[CTRL_ONESHOT];
   assign flags_w1c = wr_en && (addr == ADDR_FLAGS);
   assign timed_out = ((state == REQ) || (state == BUSY)) && (to_cnt == TW'(TIMEOUT_CYC));
   assign capt      = (state == CAPTURE);

   joy_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk      (clk),
      .reset    (reset),
      .run      (ctrl[CTRL_RUN]),
      .period   (period),
      .poll_req (poll_req)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A done pulse arriving on the timeout cycle still counts as a completed poll.
   always_comb begin
      state_nxt  = state;
      poll_start = 1'b0;
      set_to     = 1'b0;
      unique case (state)
         IDLE: begin
            if ((poll_req && ctrl[CTRL_RUN]) || one_shot) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            poll_start = 1'b1;
            if (timed_out) begin
               state_nxt = IDLE;
               set_to    = 1'b1;
            end else if (poll_busy) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (poll_done) begin
               state_nxt = CAPTURE;
            end else if (timed_out) begin
               state_nxt = IDLE;
               set_to    = 1'b1;
            end
         end
         CAPTURE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state == IDLE) begin
         to_cnt <= '0;
      end else if ((state == REQ) || (state == BUSY)) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap1 <= '0;
         cap2 <= '0;
      end else if ((state == BUSY) && poll_done) begin
         cap1 <= {type1, status1};
         cap2 <= {type2, status2};
      end
   end

`ifdef JOY_DEBOUNCE_EN
   logic [13:0] cand1, cand2;

   // Candidates start equal to the shadows, so a lone glitch never matches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand1 <= '0;
         cand2 <= '0;
      end else if (capt) begin
         if (ctrl[CTRL_P1_EN]) begin
            cand1 <= cap1;
         end
         if (ctrl[CTRL_P2_EN]) begin
            cand2 <= cap2;
         end
      end
   end

   assign upd1 = capt && ctrl[CTRL_P1_EN] && (cap1 != shadow1) && (cap1 == cand1);
   assign upd2 = capt && ctrl[CTRL_P2_EN] && (cap2 != shadow2) && (cap2 == cand2);
`else
   assign upd1 = capt && ctrl[CTRL_P1_EN] && (cap1 != shadow1);
   assign upd2 = capt && ctrl[CTRL_P2_EN] && (cap2 != shadow2);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow1 <= '0;
         shadow2 <= '0;
         frame   <= '0;
      end else begin
         if (upd1) begin
            shadow1 <= cap1;
         end
         if (upd2) begin
            shadow2 <= cap2;
         end
         if (capt) begin
            frame <= frame + 8'd1;
         end
      end
   end

   // Hardware set takes priority over a same-cycle write-1-to-clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_p1 <= 1'b0;
         flag_p2 <= 1'b0;
         flag_to <= 1'b0;
      end else begin
         flag_p1 <= upd1   || (flag_p1 && !(flags_w1c && wdata[FLAG_P1]));
         flag_p2 <= upd2   || (flag_p2 && !(flags_w1c && wdata[FLAG_P2]));
         flag_to <= set_to || (flag_to && !(flags_w1c && wdata[FLAG_TIMEOUT]));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl   <= CTRL_RESET;
         period <= 8'd1;
      end else if (wr_en) begin
         if (addr == ADDR_CTRL) begin
            ctrl <= wdata[3:0];
         end
         if (addr == ADDR_PERIOD) begin
            period <= wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= ctrl[CTRL_IRQ_EN] && (flag_p1 || flag_p2 || flag_to);
      end
   end

   // Low-byte reads snapshot the high byte so a two-byte read stays coherent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata     <= '0;
         hold1     <= '0;
         hold2     <= '0;
         hold1_vld <= 1'b0;
         hold2_vld <= 1'b0;
      end else if (rd_en) begin
         unique case (addr)
            ADDR_CTRL:   rdata <= {4'b0000, ctrl};
            ADDR_PERIOD: rdata <= period;
            ADDR_S1L: begin
               rdata     <= shadow1[7:0];
               hold1     <= pad_high_byte(shadow1);
               hold1_vld <= 1'b1;
            end
            ADDR_S1H: begin
               rdata     <= hold1_vld ? hold1 : pad_high_byte(shadow1);
               hold1_vld <= 1'b0;
            end
            ADDR_S2L: begin
               rdata     <= shadow2[7:0];
               hold2     <= pad_high_byte(shadow2);
               hold2_vld <= 1'b1;
            end
            ADDR_S2H: begin
               rdata     <= hold2_vld ? hold2 : pad_high_byte(shadow2);
               hold2_vld <= 1'b0;
            end
            ADDR_FLAGS:  rdata <= {(state != IDLE), flag_to, 4'b0000, flag_p2, flag_p1};
            ADDR_FRAME:  rdata <= frame;
            default:     rdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_joy_poll_ctrl.sv
// Self-checking bench for joy_poll_ctrl: a behavioural poller plus a read
// scoreboard comparing each register read against bench-computed values.
module tb_joy_poll_ctrl;

   localparam int CLK_DIV    = 40;
   localparam int TIMEOUT    = 200;
   localparam int PERIOD_CYC = 2 * CLK_DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [2:0]  addr = '0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata;
   logic        irq;
   logic        poll_start;
   logic        poll_busy = 1'b0;
   logic        poll_done = 1'b0;
   logic [11:0] status1 = '0;
   logic [11:0] status2 = '0;
   logic [1:0]  type1 = '0;
   logic [1:0]  type2 = '0;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   poll_count = 0;
   int   last_start_cyc = 0;
   bit   hang = 1'b0;
   logic ps_prev = 1'b0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   joy_poll_ctrl #(
      .CLK_DIV     (CLK_DIV),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cs         (cs),
      .rd         (rd),
      .wr         (wr),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .irq        (irq),
      .poll_start (poll_start),
      .poll_busy  (poll_busy),
      .poll_done  (poll_done),
      .status1    (status1),
      .status2    (status2),
      .type1      (type1),
      .type2      (type2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (poll_start && !ps_prev) begin
         poll_count++;
         last_start_cyc = cyc;
      end
      ps_prev = poll_start;
   end

   // Poller model: acknowledge one cycle after the request, finish 30 later.
   initial begin
      forever begin
         @(negedge clk);
         if (poll_start && !poll_busy && !reset) begin
            poll_busy = 1'b1;
            repeat (30) @(negedge clk);
            if (!hang) begin
               poll_done = 1'b1;
               @(negedge clk);
               poll_done = 1'b0;
            end
            poll_busy = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic cpuRead(input string tag, input logic [2:0] a, input logic [7:0] exp);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      checkOutput(tag_q.pop_front(), {24'd0, rdata}, {24'd0, exp_q.pop_front()});
   endtask

   task automatic waitPoll(input int target, input int budget, input string tag);
      int n = 0;
      while (poll_count < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, poll_count, target);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int c1, c4, pc;

      // Reset state
      waitCycles(3);
      checkOutput("rst_rdata", {24'd0, rdata}, 32'h0);
      checkOutput("rst_irq", {31'd0, irq}, 32'h0);
      checkOutput("rst_poll_start", {31'd0, poll_start}, 32'h0);
      reset = 1'b0;
      cpuRead("rst_ctrl", 3'd0, 8'h0C);
      cpuRead("rst_period", 3'd1, 8'h01);
      cpuRead("rst_flags", 3'd6, 8'h00);
      cpuRead("rst_frame", 3'd7, 8'h00);

      // Periodic polling and first capture
      status1 = 12'h0A5; type1 = 2'b10;
      applyStimulus(3'd1, 8'd2);
      applyStimulus(3'd0, 8'h0F);
      waitPoll(1, 3 * PERIOD_CYC, "poll1_seen");
      c1 = last_start_cyc;
      waitCycles(40);
      cpuRead("cap_s1l", 3'd2, 8'hA5);
      cpuRead("cap_s1h", 3'd3, 8'h80);
      cpuRead("cap_flags", 3'd6, 8'h01);
      checkOutput("cap_irq", {31'd0, irq}, 32'h1);
      applyStimulus(3'd6, 8'h01);
      checkOutput("w1c_irq_lat", {31'd0, irq}, 32'h1);
      waitCycles(1);
      checkOutput("w1c_irq_clr", {31'd0, irq}, 32'h0);
      waitPoll(2, 2 * PERIOD_CYC, "poll2_seen");
      checkOutput("poll_interval", last_start_cyc - c1, PERIOD_CYC);
      waitCycles(40);
      cpuRead("frame2", 3'd7, 8'h02);
      cpuRead("nochange_flags", 3'd6, 8'h00);

      // Coherent high-byte read across a capture
      cpuRead("coh_s1l", 3'd2, 8'hA5);
      status1 = 12'hF00;
      waitPoll(3, 2 * PERIOD_CYC, "poll3_seen");
      waitCycles(40);
      cpuRead("coh_s1h_held", 3'd3, 8'h80);
      cpuRead("coh_s1l_new", 3'd2, 8'h00);
      cpuRead("coh_s1h_new", 3'd3, 8'h8F);
      cpuRead("coh_flags", 3'd6, 8'h01);
      cpuRead("frame3", 3'd7, 8'h03);

      // Timeout: poller never finishes
      hang = 1'b1;
      applyStimulus(3'd6, 8'h41);
      waitPoll(4, 2 * PERIOD_CYC, "poll4_seen");
      c4 = last_start_cyc;
      while (cyc < c4 + 100) @(negedge clk);
      cpuRead("to_busy", 3'd6, 8'h80);
      while (cyc < c4 + TIMEOUT + 20) @(negedge clk);
      cpuRead("to_flags", 3'd6, 8'h40);
      cpuRead("to_s1l", 3'd2, 8'h00);
      cpuRead("to_s1h", 3'd3, 8'h8F);
      checkOutput("to_irq", {31'd0, irq}, 32'h1);
      hang = 1'b0;
      waitPoll(5, 2 * PERIOD_CYC, "poll5_seen");
      checkOutput("to_next_poll", last_start_cyc - c4, 3 * PERIOD_CYC);
      waitCycles(40);
      cpuRead("frame_after_to", 3'd7, 8'h04);

      // One-shot with run off, port 2 disabled
      applyStimulus(3'd0, 8'h04);
      applyStimulus(3'd6, 8'h43);
      status2 = 12'h123; type2 = 2'b01;
      status1 = 12'h3C0; type1 = 2'b00;
      pc = poll_count;
      applyStimulus(3'd0, 8'h14);
      waitCycles(200);
      checkOutput("oneshot_count", poll_count, pc + 1);
      cpuRead("os_flags", 3'd6, 8'h01);
      cpuRead("os_s2l", 3'd4, 8'h00);
      cpuRead("os_s2h", 3'd5, 8'h00);
      cpuRead("os_s1l", 3'd2, 8'hC0);
      cpuRead("os_s1h", 3'd3, 8'h03);
      cpuRead("os_ctrl", 3'd0, 8'h04);
      cpuRead("os_frame", 3'd7, 8'h05);
      checkOutput("os_irq_dis", {31'd0, irq}, 32'h0);

      // Reset during BUSY
      applyStimulus(3'd0, 8'h0F);
      waitPoll(pc + 2, 2 * PERIOD_CYC, "busy_poll_seen");
      waitCycles(5);
      checkOutput("pre_rst_irq", {31'd0, irq}, 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_rdata", {24'd0, rdata}, 32'h0);
      checkOutput("mid_rst_irq", {31'd0, irq}, 32'h0);
      checkOutput("mid_rst_poll_start", {31'd0, poll_start}, 32'h0);
      waitCycles(3);
      reset = 1'b0;
      pc = poll_count;
      waitCycles(300);
      checkOutput("post_rst_no_poll", poll_count, pc);
      cpuRead("post_rst_ctrl", 3'd0, 8'h0C);
      cpuRead("post_rst_frame", 3'd7, 8'h00);
      cpuRead("post_rst_flags", 3'd6, 8'h00);
      cpuRead("post_rst_s1l", 3'd2, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
